// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard input path.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;

endpackage

// File: rtl/ps2_tty_input_if.sv
// Pop-style read handshake between the keyboard character FIFO and the cpu.
interface ps2_tty_input_if;
  logic       tty_read;
  logic       tty_read_valid;
  logic [7:0] tty_read_data;

  modport master (output tty_read, input tty_read_valid, input tty_read_data);
  modport slave  (input tty_read, output tty_read_valid, output tty_read_data);
endinterface

// File: rtl/ps2_scancode_to_ascii.sv
// Combinational scan-code set 2 to ASCII lookup; unmapped codes give 0.
module ps2_scancode_to_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] scancode_i,
  input  logic       shift_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = 8'h00;
    case (scancode_i)
      8'h1C: ascii_o = shift_i ? "A" : "a";
      8'h32: ascii_o = shift_i ? "B" : "b";
      8'h21: ascii_o = shift_i ? "C" : "c";
      8'h23: ascii_o = shift_i ? "D" : "d";
      8'h24: ascii_o = shift_i ? "E" : "e";
      8'h2B: ascii_o = shift_i ? "F" : "f";
      8'h34: ascii_o = shift_i ? "G" : "g";
      8'h33: ascii_o = shift_i ? "H" : "h";
      8'h43: ascii_o = shift_i ? "I" : "i";
      8'h3B: ascii_o = shift_i ? "J" : "j";
      8'h42: ascii_o = shift_i ? "K" : "k";
      8'h4B: ascii_o = shift_i ? "L" : "l";
      8'h3A: ascii_o = shift_i ? "M" : "m";
      8'h31: ascii_o = shift_i ? "N" : "n";
      8'h44: ascii_o = shift_i ? "O" : "o";
      8'h4D: ascii_o = shift_i ? "P" : "p";
      8'h15: ascii_o = shift_i ? "Q" : "q";
      8'h2D: ascii_o = shift_i ? "R" : "r";
      8'h1B: ascii_o = shift_i ? "S" : "s";
      8'h2C: ascii_o = shift_i ? "T" : "t";
      8'h3C: ascii_o = shift_i ? "U" : "u";
      8'h2A: ascii_o = shift_i ? "V" : "v";
      8'h1D: ascii_o = shift_i ? "W" : "w";
      8'h22: ascii_o = shift_i ? "X" : "x";
      8'h35: ascii_o = shift_i ? "Y" : "y";
      8'h1A: ascii_o = shift_i ? "Z" : "z";
      8'h45: ascii_o = shift_i ? ")" : "0";
      8'h16: ascii_o = shift_i ? "!" : "1";
      8'h1E: ascii_o = shift_i ? "@" : "2";
      8'h26: ascii_o = shift_i ? "#" : "3";
      8'h25: ascii_o = shift_i ? "$" : "4";
      8'h2E: ascii_o = shift_i ? "%" : "5";
      8'h36: ascii_o = shift_i ? "^" : "6";
      8'h3D: ascii_o = shift_i ? "&" : "7";
      8'h3E: ascii_o = shift_i ? "*" : "8";
      8'h46: ascii_o = shift_i ? "(" : "9";
      8'h29: ascii_o = ASCII_SPACE;
      8'h5A: ascii_o = ASCII_LF;
      8'h66: ascii_o = ASCII_BS;
      8'h0D: ascii_o = ASCII_TAB;
      8'h76: ascii_o = ASCII_ESC;
      default: ascii_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_tty_input.sv
// PS/2 keyboard receiver, scan-code decoder and character FIFO feeding the cpu tty read path.
module ps2_tty_input
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_tty_input_if.slave tty,
  output logic rx_error,
  output logic overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0] clkSync_q, dataSync_q;
  logic       clkPrev_q;
  logic       fallEdge, rxBit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
      clkPrev_q  <= 1'b1;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk};
      dataSync_q <= {dataSync_q[0], ps2_data};
      clkPrev_q  <= clkSync_q[1];
    end
  end

  assign fallEdge = clkPrev_q & ~clkSync_q[1];
  assign rxBit    = dataSync_q[1];

  rx_state_e   state_q, state_d;
  logic [3:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d, code_q, code_d;
  logic        parity_q, parity_d, codeStrobe_q, codeStrobe_d, rxError_q, rxError_d;
  logic [TW-1:0] timer_q, timer_d;

  // Timer saturates one short of the limit so the RECV check fires exactly TIMEOUT_CYCLES after an edge.
  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    code_d       = code_q;
    codeStrobe_d = 1'b0;
    rxError_d    = 1'b0;
    timer_d      = timer_q;
    if (fallEdge) timer_d = '0;
    else if (timer_q != TW'(TIMEOUT_CYCLES - 1)) timer_d = timer_q + TW'(1);
    case (state_q)
      IDLE: begin
        if (fallEdge) begin
          if (!rxBit) begin
            state_d  = RECV;
            bitCnt_d = 4'd0;
          end else begin
            rxError_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (fallEdge) begin
          if (bitCnt_q < 4'd8) begin
            shift_d  = {rxBit, shift_q[7:1]};
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (bitCnt_q == 4'd8) begin
            parity_d = rxBit;
            bitCnt_d = 4'd9;
          end else begin
            state_d = IDLE;
            if ((^{shift_q, parity_q}) && rxBit) begin
              codeStrobe_d = 1'b1;
              code_d       = shift_q;
            end else begin
              rxError_d = 1'b1;
            end
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          rxError_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bitCnt_q     <= 4'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      code_q       <= 8'h00;
      codeStrobe_q <= 1'b0;
      rxError_q    <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      code_q       <= code_d;
      codeStrobe_q <= codeStrobe_d;
      rxError_q    <= rxError_d;
      timer_q      <= timer_d;
    end
  end

  logic       ext_q, ext_d, brk_q, brk_d, shiftL_q, shiftL_d, shiftR_q, shiftR_d;
  logic       push_q, push_d;
  logic [7:0] pushData_q, pushData_d, asciiChar;

  ps2_scancode_to_ascii u_map (
    .scancode_i (code_q),
    .shift_i    (shiftL_q | shiftR_q),
    .ascii_o    (asciiChar)
  );

  // Prefix bytes only arm flags; the next ordinary byte consumes and clears them.
  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    shiftL_d   = shiftL_q;
    shiftR_d   = shiftR_q;
    push_d     = 1'b0;
    pushData_d = pushData_q;
    if (codeStrobe_q) begin
      if (code_q == SC_EXT) ext_d = 1'b1;
      else if (code_q == SC_BREAK) brk_d = 1'b1;
      else begin
        if (code_q == SC_LSHIFT) shiftL_d = !brk_q;
        else if (code_q == SC_RSHIFT) shiftR_d = !brk_q;
        else if (!brk_q && !ext_q && asciiChar != 8'h00) begin
          push_d     = 1'b1;
          pushData_d = asciiChar;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      shiftL_q   <= 1'b0;
      shiftR_q   <= 1'b0;
      push_q     <= 1'b0;
      pushData_q <= 8'h00;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      shiftL_q   <= shiftL_d;
      shiftR_q   <= shiftR_d;
      push_q     <= push_d;
      pushData_q <= pushData_d;
    end
  end

  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wrPtr_q, rdPtr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic                       full, empty, pop, doPush, overflow_q;

  assign full   = (count_q == (FIFO_DEPTH_LOG2 + 1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign pop    = tty.tty_read && !empty;
  assign doPush = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      overflow_q <= push_q && full && !pop;
    end
  end

  assign tty.tty_read_valid = !empty;
  assign tty.tty_read_data  = empty ? 8'h00 : mem_q[rdPtr_q];
  assign rx_error           = rxError_q;
  assign overflow           = overflow_q;

endmodule

// File: tb/tb_ps2_tty_input.sv
// Scoreboard bench for ps2_tty_input: directed key sequences, monitor pops and compares characters.
module tb_ps2_tty_input;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 8;
  localparam int GAP     = 20;

  logic clk, reset, ps2Clk, ps2Data, rxError, overflow;
  logic popEnable, popReq;
  int   checks, failures, rxErrCount, ovfCount;
  logic [7:0] expQ[$];

  ps2_tty_input_if ttyIf ();

  ps2_tty_input #(.TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2Clk),
    .ps2_data (ps2Data),
    .tty      (ttyIf),
    .rx_error (rxError),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drives nBits of an 11-bit frame; with holdLow it returns right after the last falling edge.
  task automatic applyStimulus(input logic [7:0] code, input bit badParity, input int nBits, input bit holdLow);
    logic [10:0] frame;
    frame = {1'b1, (~^code) ^ badParity, code, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2Data = frame[i];
      repeat (HALF) @(negedge clk);
      ps2Clk = 1'b0;
      if (holdLow && i == nBits - 1) return;
      repeat (HALF) @(negedge clk);
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic sendKey(input logic [7:0] code);
    applyStimulus(code, 1'b0, 11, 1'b0);
  endtask

  task automatic releaseLine();
    repeat (HALF) @(negedge clk);
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic drainAndCheck(input string name);
    int n;
    popEnable = 1'b1;
    n = 0;
    while ((expQ.size() != 0 || ttyIf.tty_read_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput({name, "_pending"}, expQ.size(), 0);
    checkOutput({name, "_valid"}, int'(ttyIf.tty_read_valid), 0);
    checkOutput({name, "_data"}, int'(ttyIf.tty_read_data), 0);
    popEnable = 1'b0;
    expQ.delete();
  endtask

  // Monitor: counts error pulses and pops/compares whenever a character is presented.
  initial begin
    logic rd;
    logic [7:0] expChar;
    ttyIf.tty_read = 1'b0;
    forever begin
      @(negedge clk);
      rd = 1'b0;
      if (rxError) rxErrCount++;
      if (overflow) ovfCount++;
      if ((popEnable || popReq) && ttyIf.tty_read_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL char_unexpected actual=%0h expected=none", ttyIf.tty_read_data);
        end else begin
          expChar = expQ.pop_front();
          checkOutput("char", int'(ttyIf.tty_read_data), int'(expChar));
        end
        rd = 1'b1;
      end
      ttyIf.tty_read = rd;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0, o0, n;
    bit seen;
    checks = 0; failures = 0; rxErrCount = 0; ovfCount = 0;
    reset = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1; popEnable = 1'b0; popReq = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", int'(ttyIf.tty_read_valid), 0);
    checkOutput("reset_data", int'(ttyIf.tty_read_data), 0);
    checkOutput("reset_rx_error", int'(rxError), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    expQ.push_back(8'h61);
    sendKey(8'h1C);
    checkOutput("single_valid", int'(ttyIf.tty_read_valid), 1);
    drainAndCheck("single");

    expQ.push_back(8'h41); expQ.push_back(8'h61);
    sendKey(8'h12); sendKey(8'h1C); sendKey(8'hF0); sendKey(8'h1C);
    sendKey(8'hF0); sendKey(8'h12); sendKey(8'h1C);
    drainAndCheck("shift_seq");

    expQ.push_back(8'h31); expQ.push_back(8'h21); expQ.push_back(8'h30); expQ.push_back(8'h29);
    sendKey(8'h16);
    sendKey(8'h12); sendKey(8'h16); sendKey(8'h45); sendKey(8'hF0); sendKey(8'h12);
    sendKey(8'h45);
    sendKey(8'h59); sendKey(8'h1A); sendKey(8'hF0); sendKey(8'h59);
    expQ.delete();
    expQ.push_back(8'h31); expQ.push_back(8'h21); expQ.push_back(8'h29);
    expQ.push_back(8'h30); expQ.push_back(8'h5A);
    drainAndCheck("digits");

    expQ.push_back(8'h20); expQ.push_back(8'h0A); expQ.push_back(8'h08);
    expQ.push_back(8'h09); expQ.push_back(8'h1B); expQ.push_back(8'h61);
    sendKey(8'h29); sendKey(8'h5A); sendKey(8'h66); sendKey(8'h0D); sendKey(8'h76);
    sendKey(8'h05);
    sendKey(8'hE0); sendKey(8'h75); sendKey(8'hE0); sendKey(8'hF0); sendKey(8'h75);
    sendKey(8'h1C);
    drainAndCheck("controls_ext");

    e0 = rxErrCount;
    applyStimulus(8'h1C, 1'b1, 11, 1'b0);
    checkOutput("parity_err_pulses", rxErrCount - e0, 1);
    drainAndCheck("parity");

    e0 = rxErrCount;
    applyStimulus(8'h1C, 1'b0, 4, 1'b1);
    n = 0; seen = 1'b0;
    while (!seen && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
      if (rxError) seen = 1'b1;
    end
    checkOutput("timeout_latency", seen ? n : -1, TIMEOUT + 3);
    releaseLine();
    checkOutput("timeout_err_pulses", rxErrCount - e0, 1);
    expQ.push_back(8'h0A);
    sendKey(8'h5A);
    drainAndCheck("after_timeout");

    o0 = ovfCount;
    for (int i = 0; i < 16; i++) begin
      expQ.push_back(8'h61);
      sendKey(8'h1C);
    end
    sendKey(8'h32);
    checkOutput("ovf_pulses", ovfCount - o0, 1);
    checkOutput("full_valid", int'(ttyIf.tty_read_valid), 1);
    expQ.push_back(8'h63);
    applyStimulus(8'h21, 1'b0, 11, 1'b1);
    repeat (4) @(posedge clk);
    #1 popReq = 1'b1;
    @(posedge clk);
    #1 popReq = 1'b0;
    releaseLine();
    checkOutput("ovf_coincident_pulses", ovfCount - o0, 1);
    checkOutput("ovf_coincident_pending", expQ.size(), 16);
    drainAndCheck("overflow");

    sendKey(8'h1C); sendKey(8'h32); sendKey(8'h21);
    applyStimulus(8'h24, 1'b0, 5, 1'b1);
    checkOutput("pre_reset_valid", int'(ttyIf.tty_read_valid), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_valid", int'(ttyIf.tty_read_valid), 0);
    checkOutput("async_reset_data", int'(ttyIf.tty_read_data), 0);
    checkOutput("async_reset_rx_error", int'(rxError), 0);
    ps2Clk = 1'b1; ps2Data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    expQ.push_back(8'h65);
    sendKey(8'h24);
    drainAndCheck("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
